// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: FSM encoding, AXI field
// constants and the legacy bus-width macros used by the core-side wrappers.
`ifndef SRAM_AXI_BRIDGE_DEFINES
`define SRAM_AXI_BRIDGE_DEFINES
`define DataBus 31:0
`define AddrBus 31:0
`define WriteEn 3:0
`endif

package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_BYTE   = 3'd0;
    localparam logic [2:0] SIZE_HALF   = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR are the only responses treated as bus errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/wstrb_to_axi_size.sv
// Maps the processor byte-enable pattern onto an AXI transfer size and the
// low address bits of the first enabled byte. Unrecognised patterns fall back
// to a full-word transfer at offset 0 and rely on wstrb to mask bytes.
module wstrb_to_axi_size
    import sram_axi_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic [2:0] awsize,
    output logic [1:0] offset
);

    // Decode the byte-enable pattern into size and offset.
    always_comb begin
        awsize = SIZE_WORD;
        offset = 2'd0;
        case (wen)
            4'b0001: begin awsize = SIZE_BYTE; offset = 2'd0; end
            4'b0010: begin awsize = SIZE_BYTE; offset = 2'd1; end
            4'b0100: begin awsize = SIZE_BYTE; offset = 2'd2; end
            4'b1000: begin awsize = SIZE_BYTE; offset = 2'd3; end
            4'b0011: begin awsize = SIZE_HALF; offset = 2'd0; end
            4'b1100: begin awsize = SIZE_HALF; offset = 2'd2; end
            default: begin awsize = SIZE_WORD; offset = 2'd0; end
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Single-outstanding SRAM-port to AXI4 single-beat master bridge.
// One instance sits on each processor port and produces its stall.
// Optional: define BRIDGE_RESP_ERR_EN to add the bus_err output, which
// flags SLVERR/DECERR responses during the completion cycle.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for sram_en; captures the request when it arrives
// ST_RD_ADDR | arvalid high until arready
// ST_RD_DATA | rready high until rvalid; read data latched
// ST_WR_REQ  | awvalid/wvalid high, each dropped after its own handshake
// ST_WR_RESP | bready high until bvalid
// ST_DONE    | single completion cycle; sram_wait low
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sram_en,
    input  logic [DATA_W/8-1:0]   sram_wen,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_wait,
    output logic [3:0]            arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [3:0]            awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
`ifdef BRIDGE_RESP_ERR_EN
   ,output logic                  bus_err
`endif
);

    bridge_state_e state;
    bridge_state_e state_next;

    // Word address only: the low two bits are rebuilt from the strobes.
    logic [ADDR_W-3:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wen_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                aw_ok;
    logic                w_ok;
    logic [1:0]          wr_offset;

    logic unused_inputs;
    assign unused_inputs = ^{sram_addr[1:0], rresp, bresp};

    wstrb_to_axi_size u_size (
        .wen    (wen_q),
        .awsize (awsize),
        .offset (wr_offset)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and AXI handshake outputs.
    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sram_en)
                    state_next = (sram_wen == '0) ? ST_RD_ADDR : ST_WR_REQ;
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_next = ST_DONE;
            end
            ST_WR_REQ: begin
                awvalid = !aw_ok;
                wvalid  = !w_ok;
                if ((aw_ok || awready) && (w_ok || wready))
                    state_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, read-data latch and per-channel write handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            rdata_q <= '0;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
        end else begin
            if (state == ST_IDLE && sram_en) begin
                addr_q  <= sram_addr[ADDR_W-1:2];
                wdata_q <= sram_wdata;
                wen_q   <= sram_wen;
            end
            if (state == ST_RD_DATA && rvalid)
                rdata_q <= rdata;
            if (state == ST_WR_REQ && state_next == ST_WR_REQ) begin
                if (awvalid && awready) aw_ok <= 1'b1;
                if (wvalid && wready)   w_ok  <= 1'b1;
            end else begin
                aw_ok <= 1'b0;
                w_ok  <= 1'b0;
            end
        end
    end

`ifdef BRIDGE_RESP_ERR_EN
    logic [1:0] resp_q;

    // Hold the response of the current transaction for the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= RESP_OKAY;
        end else begin
            if (rvalid && rready) resp_q <= rresp;
            if (bvalid && bready) resp_q <= bresp;
        end
    end

    assign bus_err = (state == ST_DONE) && resp_is_err(resp_q);
`endif

    assign sram_wait  = sram_en && (state != ST_DONE);
    assign sram_rdata = rdata_q;

    assign arid    = AXI_ID;
    assign araddr  = {addr_q, 2'b00};
    assign arlen   = 8'd0;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = {addr_q, wr_offset};
    assign awlen   = 8'd0;
    assign awburst = BURST_INCR;

    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: directed requests push expected AXI
// beats and completions into queues; a monitor pops and compares them as the
// DUT presents handshakes and completion cycles. A reactive slave model with
// programmable ready delays and responses drives the AXI inputs.
`timescale 1ns/1ps
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = '0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_wdata = '0;
    logic [31:0] sram_rdata;
    logic        sram_wait;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wvalid, bready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
`ifdef BRIDGE_RESP_ERR_EN
    logic        bus_err;
`endif

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_wait(sram_wait),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef BRIDGE_RESP_ERR_EN
       ,.bus_err(bus_err)
`endif
    );

    typedef struct { logic [31:0] addr; logic [2:0] size; } ax_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
    typedef struct {
        logic [31:0] rdata;
        int          wait_cyc;   // -1: not checked
        bit          is_write;
        int          aw_cyc;     // -1: not checked
        int          w_cyc;
        logic        err;
    } done_exp_t;

    ax_exp_t   ar_q[$];
    ax_exp_t   aw_q[$];
    w_exp_t    w_q[$];
    done_exp_t done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // slave configuration
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [31:0] rd_val = '0;
    logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reactive AXI slave: drives inputs on the falling edge.
    initial begin
        int  ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
        bit  ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        bit  s_aw_done = 0, s_w_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
                s_aw_done = 0; s_w_done = 0;
            end else begin
                if (r_hs) rvalid = 0;
                if (b_hs) bvalid = 0;
                if (ar_hs) begin rvalid = 1; rdata = rd_val; rresp = rresp_val; end
                if (aw_hs) s_aw_done = 1;
                if (w_hs)  s_w_done  = 1;
                if (s_aw_done && s_w_done && !bvalid) begin
                    bvalid = 1; bresp = bresp_val; s_aw_done = 0; s_w_done = 0;
                end
                if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat or completes.
    initial begin
        int wait_cnt = 0, aw_cyc = 0, w_cyc = 0, aw_beats = 0, w_beats = 0;
        bit prev_b_hs = 0, prev_r_hs = 0;
        ax_exp_t   ea;
        w_exp_t    ew;
        done_exp_t ed;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                wait_cnt = 0; aw_cyc = 0; w_cyc = 0; aw_beats = 0; w_beats = 0;
                prev_b_hs = 0; prev_r_hs = 0;
            end else begin
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) flag_fail("unexpected_ar_beat");
                    else begin
                        ea = ar_q.pop_front();
                        check("araddr", araddr, ea.addr);
                        check("arsize", {29'd0, arsize}, {29'd0, ea.size});
                        check("ar_fixed", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01});
                    end
                end
                if (awvalid) aw_cyc++;
                if (wvalid)  w_cyc++;
                if (awvalid && awready) begin
                    aw_beats++;
                    if (aw_q.size() == 0) flag_fail("unexpected_aw_beat");
                    else begin
                        ea = aw_q.pop_front();
                        check("awaddr", awaddr, ea.addr);
                        check("awsize", {29'd0, awsize}, {29'd0, ea.size});
                        check("aw_fixed", {awid, awlen, awburst}, {4'd0, 8'd0, 2'b01});
                    end
                end
                if (wvalid && wready) begin
                    w_beats++;
                    if (w_q.size() == 0) flag_fail("unexpected_w_beat");
                    else begin
                        ew = w_q.pop_front();
                        check("wdata", wdata, ew.data);
                        check("wstrb_wlast", {wstrb, wlast}, {ew.strb, 1'b1});
                    end
                end
                if (bready)
                    check("bready_after_aw_and_w", {aw_beats, w_beats}, {32'd1, 32'd1});
                if (sram_en && sram_wait) wait_cnt++;
                if (sram_en && !sram_wait) begin
                    if (done_q.size() == 0) flag_fail("unexpected_done");
                    else begin
                        ed = done_q.pop_front();
                        check("sram_rdata", sram_rdata, ed.rdata);
                        if (ed.wait_cyc >= 0) check("wait_cycles", wait_cnt, ed.wait_cyc);
                        if (ed.is_write) begin
                            check("done_after_b", {31'd0, prev_b_hs}, 32'd1);
                            check("aw_w_beats", {aw_beats, w_beats}, {32'd1, 32'd1});
                            if (ed.aw_cyc >= 0) check("awvalid_cycles", aw_cyc, ed.aw_cyc);
                            if (ed.w_cyc >= 0)  check("wvalid_cycles", w_cyc, ed.w_cyc);
                        end else begin
                            check("done_after_r", {31'd0, prev_r_hs}, 32'd1);
                        end
`ifdef BRIDGE_RESP_ERR_EN
                        check("bus_err_done", {31'd0, bus_err}, {31'd0, ed.err});
`endif
                    end
                    wait_cnt = 0; aw_cyc = 0; w_cyc = 0; aw_beats = 0; w_beats = 0;
                    done_cnt++;
                end
`ifdef BRIDGE_RESP_ERR_EN
                else if (bus_err) flag_fail("bus_err_outside_done");
`endif
                prev_b_hs = bvalid && bready;
                prev_r_hs = rvalid && rready;
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
        @(posedge clk); #1;
        sram_en = 1; sram_addr = a; sram_wen = wen; sram_wdata = wd;
    endtask

    task automatic wait_done(input int budget, input bit drop_en);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            @(negedge clk); #3; k++;
        end
        n_checks++;
        if (done_cnt != start) n_pass++;
        else $display("FAIL done_timeout: got no completion, expected one within %0d cycles", budget);
        if (drop_en) begin @(posedge clk); #1; sram_en = 0; end
    endtask

    task automatic push_write(input logic [31:0] a_exp, input logic [2:0] sz, input logic [31:0] wd,
                              input logic [3:0] wen, input logic [31:0] rd_keep,
                              input int awc, input int wc, input logic err);
        aw_q.push_back('{a_exp, sz});
        w_q.push_back('{wd, wen});
        done_q.push_back('{rd_keep, -1, 1'b1, awc, wc, err});
    endtask

    typedef struct { logic [3:0] wen; logic [31:0] addr; logic [31:0] wd; logic [31:0] exp_addr; logic [2:0] sz; } wr_vec_t;
    wr_vec_t wr_tab[7];

    initial begin
        wr_tab[0] = '{4'b0001, 32'h0000_2000, 32'h0000_0011, 32'h0000_2000, 3'd0};
        wr_tab[1] = '{4'b0010, 32'h0000_2000, 32'h0000_2200, 32'h0000_2001, 3'd0};
        wr_tab[2] = '{4'b1000, 32'h0000_2003, 32'h4400_0000, 32'h0000_2003, 3'd0};
        wr_tab[3] = '{4'b0011, 32'h0000_4002, 32'h0000_5566, 32'h0000_4000, 3'd1};
        wr_tab[4] = '{4'b1100, 32'h0000_4000, 32'h7788_0000, 32'h0000_4002, 3'd1};
        wr_tab[5] = '{4'b1111, 32'h0000_3003, 32'h0102_0304, 32'h0000_3000, 3'd2};
        wr_tab[6] = '{4'b0101, 32'h0000_3001, 32'h00AA_00BB, 32'h0000_3000, 3'd2};

        // reset state
        #12;
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_wait_en0", {31'd0, sram_wait}, 32'd0);
        sram_en = 1; #1;
        check("rst_wait_en1", {31'd0, sram_wait}, 32'd1);
        sram_en = 0;
        @(posedge clk); #1; rst = 0;

        // idle: no activity with en low
        repeat (3) @(negedge clk);
        #3;
        check("idle_quiet", {arvalid, awvalid, wvalid, sram_wait}, 4'b0);

        // aligned read, zero-wait slave
        rd_val = 32'hDEAD_BEEF;
        ar_q.push_back('{32'h1FC0_0004, 3'd2});
        done_q.push_back('{32'hDEAD_BEEF, 3, 1'b0, -1, -1, 1'b0});
        do_req(32'h1FC0_0004, 4'b0000, 32'h0);
        wait_done(20, 1);

        // misaligned read address is word-aligned on AR
        rd_val = 32'h1234_5678;
        ar_q.push_back('{32'h1FC0_0004, 3'd2});
        done_q.push_back('{32'h1234_5678, 3, 1'b0, -1, -1, 1'b0});
        do_req(32'h1FC0_0007, 4'b0000, 32'h0);
        wait_done(20, 1);

        // byte write
        push_write(32'h0000_1002, 3'd0, 32'h00AB_0000, 4'b0100, 32'h1234_5678, 1, 1, 1'b0);
        do_req(32'h0000_1000, 4'b0100, 32'h00AB_0000);
        wait_done(20, 1);

        // strobe-to-size table
        foreach (wr_tab[i]) begin
            push_write(wr_tab[i].exp_addr, wr_tab[i].sz, wr_tab[i].wd, wr_tab[i].wen,
                       32'h1234_5678, 1, 1, 1'b0);
            do_req(wr_tab[i].addr, wr_tab[i].wen, wr_tab[i].wd);
            wait_done(20, 1);
        end

        // split write handshakes; inputs change after capture and must be ignored
        aw_delay = 3;
        push_write(32'h0000_5000, 3'd2, 32'hCAFE_F00D, 4'b1111, 32'h1234_5678, 4, 1, 1'b0);
        do_req(32'h0000_5000, 4'b1111, 32'hCAFE_F00D);
        @(posedge clk); #1;
        sram_addr = 32'h9999_0000; sram_wen = 4'b0001; sram_wdata = 32'h0;
        wait_done(30, 1);
        aw_delay = 0;

        // read with arready stuck low, reset in the third cycle
        ar_delay = 1000;
        do_req(32'h0000_0100, 4'b0000, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; #1;
        check("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        check("rst_mid_wait_eq_en", {31'd0, sram_wait}, 32'd1);
        check("rst_mid_rdata", sram_rdata, 32'h0);
        sram_en = 0; #1;
        check("rst_mid_wait_en0", {31'd0, sram_wait}, 32'd0);
        repeat (2) @(posedge clk);
        #1; rst = 0; ar_delay = 0;
        repeat (2) @(negedge clk);
        #3;
        check("post_rst_idle", {arvalid, rready, sram_wait}, 3'b0);

        // back-to-back read then write with en held high
        rd_val = 32'hA5A5_5A5A;
        ar_q.push_back('{32'h0000_0200, 3'd2});
        done_q.push_back('{32'hA5A5_5A5A, 3, 1'b0, -1, -1, 1'b0});
        push_write(32'h0000_0300, 3'd1, 32'h0000_BEEF, 4'b0011, 32'hA5A5_5A5A, 1, 1, 1'b0);
        do_req(32'h0000_0200, 4'b0000, 32'h0);
        wait_done(20, 0);
        @(posedge clk); #1;
        sram_addr = 32'h0000_0300; sram_wen = 4'b0011; sram_wdata = 32'h0000_BEEF;
        @(negedge clk); #3;
        check("b2b_bubble", {arvalid, awvalid, sram_wait}, 3'b001);
        @(negedge clk); #3;
        check("b2b_aw_start", {arvalid, awvalid, wvalid}, 3'b011);
        wait_done(20, 1);

`ifdef BRIDGE_RESP_ERR_EN
        bresp_val = 2'b10;
        push_write(32'h0000_0400, 3'd2, 32'h1111_2222, 4'b1111, 32'hA5A5_5A5A, 1, 1, 1'b1);
        do_req(32'h0000_0400, 4'b1111, 32'h1111_2222);
        wait_done(20, 1);
        bresp_val = 2'b00;
        push_write(32'h0000_0404, 3'd2, 32'h3333_4444, 4'b1111, 32'hA5A5_5A5A, 1, 1, 1'b0);
        do_req(32'h0000_0404, 4'b1111, 32'h3333_4444);
        wait_done(20, 1);
        rresp_val = 2'b11;
        rd_val = 32'h0BAD_0BAD;
        ar_q.push_back('{32'h0000_0500, 3'd2});
        done_q.push_back('{32'h0BAD_0BAD, 3, 1'b0, -1, -1, 1'b1});
        do_req(32'h0000_0500, 4'b0000, 32'h0);
        wait_done(20, 1);
        rresp_val = 2'b00;
`endif

        repeat (4) @(posedge clk);
        #1;
        check("queues_drained", ar_q.size() + aw_q.size() + w_q.size() + done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
